trap_source_scheduler: RTL and testbench

- Clocked scheduler that gathers all virtualization trap sources into one prioritised pending set: I/O violation, software trap, intercepted interrupt and the periodic M1 tick.
- Drives the single NMI request into the trap/mode logic.
- Latches the cause on trap entry.
- Exposes a small hypervisor register interface for cause readback, clearing and source masking.
- Sits between the Nabu bus-monitor signals and the mode/trap flip-flop logic, replacing its direct NMI generation.

---
 rtl/trap_source_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_trap_source_scheduler.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_source_scheduler.sv
// ---------------------------------------------------------------------------
// trap_source_scheduler
//
// Collects every virtualization trap source into one prioritised pending set
// and drives the single NMI request into the trap/mode flip-flop logic. It
// replaces the direct NMI generation that used to sit on the Nabu
// bus-monitor signals.
//
// Sources (pending bit / cause code):
//   bit0 IOV  (cause 1) : rising edge of io_violation outside trap mode, sticky
//   bit1 SW   (cause 2) : sw_trap strobe, sticky
//   bit2 IRQ  (cause 3) : live level of the synchronized irq_sys_n, not stored
//   bit3 TICK (cause 4) : M1 tick counter expiry, sticky
//
// On trap entry (synchronized trap_state rising) the highest-priority enabled
// source is latched into cause, and its sticky bit clears in that same clock.
//
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   m1_n             : Z80 M1 (async), falling edges drive the tick counter
//   io_violation     : I/O violation strobe (async), rising edge is an event
//   irq_sys_n        : system interrupt (async), level, active low
//   trap_state       : 1 = hypervisor (trap) mode, from the mode logic
//   virtual_enabled  : gates the NMI request and the tick counter
//   sw_trap          : single-clk software trap strobe
//   reg_wr/reg_addr/reg_wdata : hypervisor register write port
//   reg_rdata        : combinational read data selected by reg_addr
//   nmi_n            : registered NMI request, active low
//   cause            : cause code latched at the last trap entry
//   tick_irq         : one-clk pulse on tick counter expiry
//
// Register map:
//   0 : R {1'b0, cause, pending}   W1C on pending bits 0,1,3 (bit2 ignored)
//   1 : R/W {4'b0, mask}
//   2 : R/W reload[7:0]
//   3 : R/W reload[TICK_W-1:8]     (TICK_W assumed in 9..16)
// ---------------------------------------------------------------------------
module trap_source_scheduler #(
    parameter int                SYNC_STAGES = 2,
    parameter int                TICK_W      = 16,
    parameter logic [TICK_W-1:0] TICK_RESET  = 16'hFFFF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       m1_n,
    input  logic       io_violation,
    input  logic       irq_sys_n,
    input  logic       trap_state,
    input  logic       virtual_enabled,
    input  logic       sw_trap,
    input  logic       reg_wr,
    input  logic [1:0] reg_addr,
    input  logic [7:0] reg_wdata,
    output logic [7:0] reg_rdata,
    output logic       nmi_n,
    output logic [2:0] cause,
    output logic       tick_irq
);

    // Fixed priority IOV > SW > IRQ > TICK, code 0 when nothing is enabled.
    function automatic logic [2:0] prio_encode(input logic [3:0] act);
        if (act[0])      return 3'd1;
        else if (act[1]) return 3'd2;
        else if (act[2]) return 3'd3;
        else if (act[3]) return 3'd4;
        else             return 3'd0;
    endfunction

    logic [SYNC_STAGES-1:0] m1_sync;
    logic [SYNC_STAGES-1:0] io_sync;
    logic [SYNC_STAGES-1:0] irq_sync;
    logic [SYNC_STAGES-1:0] trap_sync;

    logic m1_s, io_s, irq_s, trap_s;
    logic m1_p1, io_p1, trap_p1;

    logic iov_pend, sw_pend, tick_pend;
    logic [3:0] mask;
    logic [TICK_W-1:0] reload;
    logic [TICK_W-1:0] tick_cnt;

    // ---- stage: synchronizers and 1-clk delayed copies for edge detect ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m1_sync   <= '1;
            irq_sync  <= '1;
            io_sync   <= '0;
            trap_sync <= '0;
            m1_p1     <= 1'b1;
            io_p1     <= 1'b0;
            trap_p1   <= 1'b0;
        end else begin
            m1_sync   <= {m1_sync[SYNC_STAGES-2:0],   m1_n};
            io_sync   <= {io_sync[SYNC_STAGES-2:0],   io_violation};
            irq_sync  <= {irq_sync[SYNC_STAGES-2:0],  irq_sys_n};
            trap_sync <= {trap_sync[SYNC_STAGES-2:0], trap_state};
            m1_p1     <= m1_s;
            io_p1     <= io_s;
            trap_p1   <= trap_s;
        end
    end

    assign m1_s   = m1_sync[SYNC_STAGES-1];
    assign io_s   = io_sync[SYNC_STAGES-1];
    assign irq_s  = irq_sync[SYNC_STAGES-1];
    assign trap_s = trap_sync[SYNC_STAGES-1];

    logic m1_fall, io_rise, trap_rise;
    assign m1_fall   = m1_p1 & ~m1_s;
    assign io_rise   = io_s & ~io_p1;
    assign trap_rise = trap_s & ~trap_p1;

    // ---- combinational request / decode ----
    logic [3:0] pending;
    logic [3:0] active;
    logic [2:0] entry_cause;
    logic       w1c;
    logic       iov_set, tick_step, tick_expire;
    logic       iov_auto, sw_auto, tick_auto;

    assign pending     = {tick_pend, ~irq_s, sw_pend, iov_pend};
    assign active      = pending & mask;
    assign entry_cause = prio_encode(active);
    assign w1c         = reg_wr && (reg_addr == 2'd0);

    // IOV edges seen while already in trap mode are dropped, not deferred.
    assign iov_set     = io_rise & ~trap_s;

    // The tick only runs in guest mode; a zero reload parks it completely.
    assign tick_step   = m1_fall & virtual_enabled & ~trap_s & (reload != '0);
    assign tick_expire = tick_step & (tick_cnt == '0);

    // Only the sticky bit that was chosen as the entry cause self-clears.
    assign iov_auto  = trap_rise & (entry_cause == 3'd1);
    assign sw_auto   = trap_rise & (entry_cause == 3'd2);
    assign tick_auto = trap_rise & (entry_cause == 3'd4);

    // ---- stage: pending, cause, tick counter, NMI and registers ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iov_pend  <= 1'b0;
            sw_pend   <= 1'b0;
            tick_pend <= 1'b0;
            mask      <= 4'b0000;
            reload    <= TICK_RESET;
            tick_cnt  <= '0;
            tick_irq  <= 1'b0;
            cause     <= 3'd0;
            nmi_n     <= 1'b1;
        end else begin
            // A new set always wins over a W1C or entry clear in the same clk.
            iov_pend  <= iov_set |
                         (iov_pend & ~(w1c & reg_wdata[0]) & ~iov_auto);
            sw_pend   <= sw_trap |
                         (sw_pend & ~(w1c & reg_wdata[1]) & ~sw_auto);
            tick_pend <= tick_expire |
                         (tick_pend & ~(w1c & reg_wdata[3]) & ~tick_auto);

            if (trap_rise)
                cause <= entry_cause;

            tick_irq <= tick_expire;
            if (tick_expire)
                tick_cnt <= reload;
            else if (tick_step)
                tick_cnt <= tick_cnt - TICK_W'(1);

            // trap_s forces the request off while the hypervisor runs.
            nmi_n <= ~((|active) & virtual_enabled & ~trap_s);

            // Reload writes only land in the counter at its next reload.
            if (reg_wr) begin
                case (reg_addr)
                    2'd1:    mask   <= reg_wdata[3:0];
                    2'd2:    reload <= {reload[TICK_W-1:8], reg_wdata};
                    2'd3:    reload <= {reg_wdata[TICK_W-9:0], reload[7:0]};
                    default: ;
                endcase
            end
        end
    end

    // ---- register readback ----
    always_comb begin
        reg_rdata = 8'h00;
        case (reg_addr)
            2'd0: reg_rdata = {1'b0, cause, pending};
            2'd1: reg_rdata = {4'b0000, mask};
            2'd2: reg_rdata = reload[7:0];
            2'd3: reg_rdata = 8'(reload >> 8);
            default: reg_rdata = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_trap_source_scheduler.sv
// Directed testbench for trap_source_scheduler. Inputs are driven 1 time unit
// after the rising clock edge and outputs are sampled at the same point.
module tb_trap_source_scheduler;

    logic       clk;
    logic       rst_n;
    logic       m1_n;
    logic       io_violation;
    logic       irq_sys_n;
    logic       trap_state;
    logic       virtual_enabled;
    logic       sw_trap;
    logic       reg_wr;
    logic [1:0] reg_addr;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata;
    logic       nmi_n;
    logic [2:0] cause;
    logic       tick_irq;

    int checks = 0;
    int errors = 0;

    trap_source_scheduler #(
        .SYNC_STAGES(2),
        .TICK_W     (16),
        .TICK_RESET (16'hFFFF)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .m1_n           (m1_n),
        .io_violation   (io_violation),
        .irq_sys_n      (irq_sys_n),
        .trap_state     (trap_state),
        .virtual_enabled(virtual_enabled),
        .sw_trap        (sw_trap),
        .reg_wr         (reg_wr),
        .reg_addr       (reg_addr),
        .reg_wdata      (reg_wdata),
        .reg_rdata      (reg_rdata),
        .nmi_n          (nmi_n),
        .cause          (cause),
        .tick_irq       (tick_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] a, input logic [7:0] exp);
        reg_addr = a;
        #1;
        chk(tag, reg_rdata, exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        reg_addr  = a;
        reg_wdata = d;
        reg_wr    = 1'b1;
        step(1);
        reg_wr    = 1'b0;
    endtask

    task automatic pulse_sw();
        sw_trap = 1'b1;
        step(1);
        sw_trap = 1'b0;
    endtask

    // One M1 cycle; reports tick_irq as seen 3 clks after the falling edge,
    // which is when a synchronized expiry shows up.
    task automatic m1_cyc(output logic p);
        m1_n = 1'b0;
        step(3);
        p = tick_irq;
        step(1);
        m1_n = 1'b1;
        step(3);
    endtask

    task automatic set_trap(input logic v);
        trap_state = v;
        step(3);
    endtask

    logic p;

    initial begin
        rst_n           = 1'b1;
        m1_n            = 1'b1;
        io_violation    = 1'b0;
        irq_sys_n       = 1'b1;
        trap_state      = 1'b0;
        virtual_enabled = 1'b1;
        sw_trap         = 1'b0;
        reg_wr          = 1'b0;
        reg_addr        = 2'd0;
        reg_wdata       = 8'h00;
        p               = 1'b0;

        // ---- reset values ----
        #2 rst_n = 1'b0;
        step(2);
        chk("rst_nmi_n", {7'd0, nmi_n}, 8'h01);
        chk("rst_tick_irq", {7'd0, tick_irq}, 8'h00);
        chk_reg("rst_reg0", 2'd0, 8'h00);
        chk_reg("rst_mask", 2'd1, 8'h00);
        chk_reg("rst_reload_lo", 2'd2, 8'hFF);
        chk_reg("rst_reload_hi", 2'd3, 8'hFF);
        rst_n = 1'b1;
        step(2);

        // ---- IOV event, NMI latency, trap entry ----
        wr(2'd1, 8'h0F);
        chk_reg("mask_rb", 2'd1, 8'h0F);
        step(1);
        io_violation = 1'b1;
        step(3);
        chk_reg("iov_pending", 2'd0, 8'h01);
        chk("iov_nmi_not_yet", {7'd0, nmi_n}, 8'h01);
        step(1);
        chk("iov_nmi_low", {7'd0, nmi_n}, 8'h00);
        io_violation = 1'b0;
        trap_state = 1'b1;
        step(2);
        chk("entry_cause_latency", {5'd0, cause}, 8'h00);
        step(1);
        chk("entry1_cause", {5'd0, cause}, 8'h01);
        chk_reg("entry1_reg0", 2'd0, 8'h10);
        chk("entry1_nmi_high", {7'd0, nmi_n}, 8'h01);
        set_trap(1'b0);

        // ---- priority sequence with IRQ held low ----
        irq_sys_n    = 1'b0;
        io_violation = 1'b1;
        pulse_sw();
        step(3);
        io_violation = 1'b0;
        chk_reg("prio_pending", 2'd0, 8'h17);
        chk("prio_nmi_low", {7'd0, nmi_n}, 8'h00);
        set_trap(1'b1);
        chk_reg("prio_entry_iov", 2'd0, 8'h16);
        set_trap(1'b0);
        set_trap(1'b1);
        chk_reg("prio_entry_sw", 2'd0, 8'h24);
        set_trap(1'b0);
        set_trap(1'b1);
        chk_reg("prio_entry_irq", 2'd0, 8'h34);
        // IOV edge while in trap is discarded
        io_violation = 1'b1;
        step(4);
        chk_reg("iov_in_trap_dropped", 2'd0, 8'h34);
        io_violation = 1'b0;
        step(3);
        set_trap(1'b0);
        irq_sys_n = 1'b1;
        step(3);
        chk_reg("irq_released", 2'd0, 8'h30);

        // ---- tick counter ----
        wr(2'd2, 8'h03);
        wr(2'd3, 8'h00);
        m1_cyc(p);
        chk("tick_prime_pulse", {7'd0, p}, 8'h01);
        chk_reg("tick_prime_pending", 2'd0, 8'h38);
        wr(2'd0, 8'h08);
        chk_reg("tick_w1c", 2'd0, 8'h30);
        for (int i = 1; i <= 4; i++) begin
            m1_cyc(p);
            chk($sformatf("tick_run_%0d", i), {7'd0, p}, (i == 4) ? 8'h01 : 8'h00);
        end
        chk_reg("tick_run_pending", 2'd0, 8'h38);
        wr(2'd0, 8'h08);
        set_trap(1'b1);
        chk_reg("tick_trap_entry_none", 2'd0, 8'h00);
        for (int i = 1; i <= 4; i++) begin
            m1_cyc(p);
            chk($sformatf("tick_frozen_%0d", i), {7'd0, p}, 8'h00);
        end
        set_trap(1'b0);
        for (int i = 1; i <= 4; i++) begin
            m1_cyc(p);
            chk($sformatf("tick_resume_%0d", i), {7'd0, p}, (i == 4) ? 8'h01 : 8'h00);
        end
        wr(2'd0, 8'h08);
        chk_reg("tick_cleared", 2'd0, 8'h00);

        // ---- W1C behaviour ----
        for (int i = 1; i <= 4; i++) m1_cyc(p);
        irq_sys_n    = 1'b0;
        io_violation = 1'b1;
        pulse_sw();
        step(3);
        io_violation = 1'b0;
        chk_reg("w1c_all_pending", 2'd0, 8'h0F);
        wr(2'd0, 8'h0B);
        chk_reg("w1c_0b", 2'd0, 8'h04);
        sw_trap   = 1'b1;
        reg_addr  = 2'd0;
        reg_wdata = 8'h02;
        reg_wr    = 1'b1;
        step(1);
        sw_trap = 1'b0;
        reg_wr  = 1'b0;
        chk_reg("w1c_set_wins", 2'd0, 8'h06);
        wr(2'd0, 8'h02);
        chk_reg("w1c_sw_clear", 2'd0, 8'h04);
        irq_sys_n = 1'b1;
        step(3);
        chk_reg("w1c_idle", 2'd0, 8'h00);

        // ---- masking and virtual_enabled ----
        wr(2'd1, 8'h00);
        irq_sys_n    = 1'b0;
        io_violation = 1'b1;
        pulse_sw();
        step(3);
        io_violation = 1'b0;
        chk_reg("mask0_pending", 2'd0, 8'h07);
        chk("mask0_nmi_high", {7'd0, nmi_n}, 8'h01);
        wr(2'd1, 8'h02);
        chk("mask2_nmi_latency", {7'd0, nmi_n}, 8'h01);
        step(1);
        chk("mask2_nmi_low", {7'd0, nmi_n}, 8'h00);
        wr(2'd1, 8'h08);
        step(1);
        chk("mask8_nmi_high", {7'd0, nmi_n}, 8'h01);
        wr(2'd1, 8'h02);
        step(1);
        chk("mask2_again_low", {7'd0, nmi_n}, 8'h00);
        virtual_enabled = 1'b0;
        step(1);
        chk("ve0_nmi_high", {7'd0, nmi_n}, 8'h01);
        virtual_enabled = 1'b1;
        step(1);

        // ---- asynchronous reset mid-trap ----
        wr(2'd0, 8'h01);
        irq_sys_n = 1'b1;
        step(3);
        chk_reg("pre_rst_pending", 2'd0, 8'h02);
        wr(2'd1, 8'h0F);
        step(1);
        set_trap(1'b1);
        chk("pre_rst_cause2", {5'd0, cause}, 8'h02);
        set_trap(1'b0);
        pulse_sw();
        step(2);
        chk("pre_rst_nmi_low", {7'd0, nmi_n}, 8'h00);
        wr(2'd2, 8'h5A);
        wr(2'd3, 8'hA5);
        chk_reg("reload_lo_rb", 2'd2, 8'h5A);
        chk_reg("reload_hi_rb", 2'd3, 8'hA5);
        trap_state = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("arst_nmi_n", {7'd0, nmi_n}, 8'h01);
        chk("arst_cause", {5'd0, cause}, 8'h00);
        chk_reg("arst_reg0", 2'd0, 8'h00);
        chk_reg("arst_mask", 2'd1, 8'h00);
        chk_reg("arst_reload_lo", 2'd2, 8'hFF);
        chk_reg("arst_reload_hi", 2'd3, 8'hFF);
        step(3);
        chk("arst_hold_nmi_n", {7'd0, nmi_n}, 8'h01);
        rst_n = 1'b1;
        step(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
